// File: rtl/memmapio_uart_tx_drain.sv
// memmapio_uart_tx_drain
// Drains the memory-mapped UART TX ring: reads the byte at the head slot,
// sends it as an 8N1 frame (LSB first) on uart_tx, then advances the head.
module memmapio_uart_tx_drain #(
  parameter int CLK_FREQ  = 27000000,
  parameter int BAUD_RATE = 115200,
  parameter int PTR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_enable,
  input  logic [PTR_WIDTH-1:0] queue_tail,
  output logic [PTR_WIDTH-1:0] queue_head,
  output logic [PTR_WIDTH-1:0] rd_addr,
  input  logic [7:0]           rd_data,
  output logic                 uart_tx,
  output logic                 busy
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           sr_q, sr_d;
  logic [PTR_WIDTH-1:0] head_q, head_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  // Next-state logic: frame sequencing, bit timing, shift register and head pointer.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    head_d  = head_q;

    case (state_q)
      S_IDLE: begin
        // Tail is sampled as it is this cycle; a same-cycle update is seen next time round.
        if (tx_enable && (head_q != queue_tail)) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // rd_addr has been stable at head since IDLE, so rd_data is valid now.
        sr_d    = rd_data;
        state_d = S_START;
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            sr_d  = {1'b0, sr_q[7:1]};
          end
        end
      end
      S_STOP: begin
        if (baud_end) begin
          // Only place the head moves; the frame is complete on the line.
          head_d  = head_q + PTR_WIDTH'(1);
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Baud counter restarts on every state change and at each bit boundary;
    // it only runs while a bit is being timed.
    if ((state_d != state_q) || baud_end ||
        (state_q == S_IDLE) || (state_q == S_FETCH)) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + CNT_W'(1);
    end

    if (state_d != S_DATA) begin
      bit_d = 3'd0;
    end
  end

  // Registered line and busy values, derived from where the FSM is heading.
  always_comb begin
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sr_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State registers; reset abandons any partial frame and returns the line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      sr_q    <= 8'd0;
      head_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      head_q  <= head_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign queue_head = head_q;
  assign rd_addr    = head_q;
  assign uart_tx    = tx_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_memmapio_uart_tx_drain.sv
// Testbench for memmapio_uart_tx_drain: a ring memory model with registered
// read, a scoreboard of queued bytes, and a UART receiver that decodes frames.
module tb_memmapio_uart_tx_drain;

  localparam int BC = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_enable = 1'b0;
  logic [7:0] queue_tail = 8'd0;
  logic [7:0] queue_head;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       uart_tx;
  logic       busy;

  memmapio_uart_tx_drain #(
    .CLK_FREQ (16),
    .BAUD_RATE(1),
    .PTR_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_enable (tx_enable),
    .queue_tail(queue_tail),
    .queue_head(queue_head),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .uart_tx   (uart_tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Ring memory with one-cycle synchronous read.
  logic [7:0] ring [0:255];
  always @(posedge clk) rd_data <= ring[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int start_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: decode frames from uart_tx sampled on the falling clock edge.
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'd0;
  logic       prev_tx = 1'b1;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_active = 1'b0;
        prev_tx   = 1'b1;
      end else begin
        check("rd_addr_eq_head", rd_addr, queue_head);
        if (!rx_active && prev_tx && (uart_tx === 1'b0)) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
          start_q.push_back(cyc);
        end else if (rx_active) begin
          rx_cnt++;
          if (rx_cnt == 8) begin
            check("start_bit_low", uart_tx, 1'b0);
            check("busy_in_frame", busy, 1'b1);
          end else if (rx_cnt >= 24 && rx_cnt <= 136 && ((rx_cnt - 8) % 16) == 0) begin
            rx_byte[(rx_cnt - 24) / 16] = uart_tx;
          end else if (rx_cnt == 152) begin
            check("stop_bit_high", uart_tx, 1'b1);
            if (exp_q.size() == 0) begin
              n_chk++;
              n_err++;
              $display("FAIL frame_unexpected: got %0h expected no frame", rx_byte);
            end else begin
              check("frame_byte", rx_byte, exp_q.pop_front());
            end
            rx_active = 1'b0;
          end
        end
        prev_tx = uart_tx;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enqueue(input logic [7:0] b);
    ring[queue_tail] = b;
    exp_q.push_back(b);
    queue_tail = queue_tail + 8'd1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    queue_tail = 8'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_head(input logic [7:0] target, input int budget, input string name);
    int n;
    n = 0;
    while (queue_head !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, queue_head, target);
  endtask

  initial begin
    int t;
    int d;
    int iter;
    int nb;
    for (int i = 0; i < 256; i++) ring[i] = 8'd0;

    // 1. reset state, then idle with an empty ring
    tick();
    tick();
    @(negedge clk);
    check("reset_uart_tx", uart_tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_head", queue_head, 8'd0);
    tick();
    rst = 1'b0;
    tx_enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_empty", {uart_tx, busy, queue_head}, {1'b1, 1'b0, 8'd0});
    end

    // 2. single frame 0x55: latency and head update timing
    start_q.delete();
    tick();
    enqueue(8'h55);
    t = cyc;
    repeat (163) begin
      @(negedge clk);
      d = cyc - t;
      if (d == 1) begin
        check("fetch_line_high", uart_tx, 1'b1);
        check("fetch_busy", busy, 1'b1);
      end
      if (d == 2)  check("start_edge", uart_tx, 1'b0);
      if (d == 17) check("start_end", uart_tx, 1'b0);
      if (d == 18) check("data_bit0", uart_tx, 1'b1);
      if (d == 161) begin
        check("stop_last_high", uart_tx, 1'b1);
        check("stop_last_busy", busy, 1'b1);
        check("head_before_end", queue_head, 8'd0);
      end
      if (d == 162) begin
        check("head_after_frame", queue_head, 8'd1);
        check("busy_after_frame", busy, 1'b0);
      end
    end
    check("start_count_t2", start_q.size(), 1);
    if (start_q.size() >= 1) check("start_latency", start_q[0] - t, 2);

    // 3. three back-to-back frames
    do_reset();
    start_q.delete();
    tick();
    enqueue(8'h00);
    enqueue(8'hFF);
    enqueue(8'hA3);
    wait_head(8'd3, 3 * 170 + 20, "head_after_three");
    check("start_count_t3", start_q.size(), 3);
    if (start_q.size() == 3) begin
      check("gap_1_2", start_q[1] - start_q[0], 10 * BC + 2);
      check("gap_2_3", start_q[2] - start_q[1], 10 * BC + 2);
    end

    // Random traffic with tx_enable toggling, advancing the ring to slot 255
    iter = 0;
    while (queue_tail != 8'd255 && iter < 3000) begin
      iter++;
      tick();
      if (exp_q.size() <= 4) begin
        nb = $urandom_range(1, 3);
        for (int k = 0; k < nb; k++) begin
          if (queue_tail != 8'd255) enqueue(8'($urandom_range(0, 255)));
        end
      end
      tx_enable = ($urandom_range(0, 7) != 0);
      repeat ($urandom_range(0, 300)) tick();
    end
    tx_enable = 1'b1;
    wait_head(8'd255, 8 * 170 + 100, "head_reach_255");

    // 4. wrap-around from slot 255 to 0
    tick();
    enqueue(8'h3C);
    check("tail_wrapped", queue_tail, 8'd0);
    wait_head(8'd0, 200, "head_wrap");

    // 5. reset during the 5th data bit of 0xF0, then full resend
    tick();
    enqueue(8'hF0);
    t = cyc;
    while (cyc < t + 2 + 5 * BC + 4) tick();
    check("bit4_of_f0", uart_tx, 1'b1);
    check("busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    tick();
    check("rst_mid_uart_tx", uart_tx, 1'b1);
    check("rst_mid_head", queue_head, 8'd0);
    check("rst_mid_busy", busy, 1'b0);
    rst = 1'b0;
    wait_head(8'd1, 200, "head_after_resend");

    // 6. tx_enable dropped during the first of two queued frames
    tx_enable = 1'b1;
    tick();
    enqueue(8'h81);
    enqueue(8'h6E);
    repeat (20) tick();
    tx_enable = 1'b0;
    wait_head(8'd2, 200, "head_after_first");
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("hold_disabled", {uart_tx, busy, queue_head}, {1'b1, 1'b0, 8'd2});
    end
    tick();
    tx_enable = 1'b1;
    t = cyc;
    repeat (3) begin
      @(negedge clk);
      d = cyc - t;
      if (d == 1) check("reenable_fetch_high", uart_tx, 1'b1);
      if (d == 2) check("reenable_start", uart_tx, 1'b0);
    end
    wait_head(8'd3, 200, "head_after_second");

    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
